// File: rtl/alu_pkg.sv
// Shared constants for the ALU command front-end: opcodes, ALU mode fields,
// status bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOTA  = 4'd5;
    localparam logic [3:0] OP_PASSB = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_DEC   = 4'd8;

    localparam logic [7:0] MODE_INV_A = 8'h01;
    localparam logic [7:0] MODE_INV_B = 8'h02;
    localparam logic [7:0] MODE_CIN   = 8'h04;

    localparam logic [4:0] FN_ADD   = 5'd1;
    localparam logic [4:0] FN_AND   = 5'd2;
    localparam logic [4:0] FN_OR    = 5'd3;
    localparam logic [4:0] FN_XOR   = 5'd4;
    localparam logic [4:0] FN_PASSA = 5'd5;
    localparam logic [4:0] FN_PASSB = 5'd6;

    localparam int ST_ZERO = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_NEG  = 2;
    localparam int ST_PAR  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } seq_state_t;

    function automatic logic [7:0] fn_mode(input logic [4:0] fn);
        return {fn, 3'b000};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Translates a sequencer opcode into the ALU mode byte plus the side flags
// the sequencer needs (force B to zero, arithmetic op, illegal op).
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output logic [7:0] mode,
    output logic       force_b_zero,
    output logic       is_arith,
    output logic       illegal
);

    // SUB and DEC reuse the adder via B inversion and carry-in
    always_comb begin
        mode         = 8'h00;
        force_b_zero = 1'b0;
        is_arith     = 1'b0;
        illegal      = 1'b0;
        case (op)
            OP_ADD: begin
                mode     = fn_mode(FN_ADD);
                is_arith = 1'b1;
            end
            OP_SUB: begin
                mode     = fn_mode(FN_ADD) | MODE_INV_B | MODE_CIN;
                is_arith = 1'b1;
            end
            OP_AND:   mode = fn_mode(FN_AND);
            OP_OR:    mode = fn_mode(FN_OR);
            OP_XOR:   mode = fn_mode(FN_XOR);
            OP_NOTA:  mode = fn_mode(FN_PASSA) | MODE_INV_A;
            OP_PASSB: mode = fn_mode(FN_PASSB);
            OP_INC: begin
                mode         = fn_mode(FN_ADD) | MODE_CIN;
                force_b_zero = 1'b1;
                is_arith     = 1'b1;
            end
            OP_DEC: begin
                mode         = fn_mode(FN_ADD) | MODE_INV_B;
                force_b_zero = 1'b1;
                is_arith     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command front-end for the registered 8-bit ALU: issues one command at a
// time, waits out the ALU latency and returns result/flags, chaining via acc.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int         ALU_LATENCY = 1,
    parameter logic [7:0] ACC_INIT    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_mode,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_status,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       rsp_err,
    output logic [7:0] acc
);

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    seq_state_t state, state_next;
    logic [2:0] wait_cnt;
    logic       arith_q;
    logic [7:0] dec_mode;
    logic       dec_force_b_zero;
    logic       dec_is_arith;
    logic       dec_illegal;
    logic       accept;
    logic       status_unused;

    alu_op_decode u_decode (
        .op           (cmd_op),
        .mode         (dec_mode),
        .force_b_zero (dec_force_b_zero),
        .is_arith     (dec_is_arith),
        .illegal      (dec_illegal)
    );

    // Ready is gated by rst_n so it reads low for the whole reset window
    assign cmd_ready     = (state == S_IDLE) && rst_n;
    assign accept        = cmd_valid && cmd_ready;
    assign status_unused = ^alu_status[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = dec_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == 3'd0) state_next = S_RESP;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_mode   <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'h00;
            rsp_flags  <= 4'h0;
            rsp_err    <= 1'b0;
            acc        <= ACC_INIT;
            wait_cnt   <= 3'd0;
            arith_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && dec_illegal) begin
                        rsp_err    <= 1'b1;
                        rsp_result <= 8'h00;
                        rsp_flags  <= 4'h0;
                        rsp_valid  <= 1'b1;
                    end else if (accept) begin
                        alu_a    <= cmd_use_acc ? acc : cmd_a;
                        alu_b    <= dec_force_b_zero ? 8'h00 : cmd_b;
                        alu_mode <= dec_mode;
                        arith_q  <= dec_is_arith;
                        wait_cnt <= LAT;
                    end
                end
                S_ISSUE: wait_cnt <= wait_cnt - 3'd1;
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        // The ALU overflow bit is sticky, so only trust it for adder ops
                        rsp_result <= alu_out;
                        rsp_flags  <= {alu_status[ST_PAR], alu_status[ST_NEG],
                                       alu_status[ST_OVF] & arith_q, alu_status[ST_ZERO]};
                        rsp_valid  <= 1'b1;
                        acc        <= alu_out;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: two instances (latency 1 and 3) each
// paired with a behavioural registered ALU with a sticky overflow bit.
module tb_alu_sequencer;

    localparam int L1 = 1;
    localparam int L3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid, cmd_ready, cmd_use_acc, rsp_valid, rsp_ready, rsp_err;
    logic [3:0] cmd_op, rsp_flags;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_mode, alu_out, alu_status, rsp_result, acc;

    logic       cmd_valid3, cmd_ready3, cmd_use_acc3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [3:0] cmd_op3, rsp_flags3;
    logic [7:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_mode3, alu_out3, alu_status3, rsp_result3, acc3;

    int n_cmp = 0;
    int n_err = 0;

    alu_sequencer #(.ALU_LATENCY(L1), .ACC_INIT(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_out(alu_out),
        .alu_status(alu_status), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc)
    );

    alu_sequencer #(.ALU_LATENCY(L3), .ACC_INIT(8'h5A)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_use_acc(cmd_use_acc3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_mode(alu_mode3), .alu_out(alu_out3),
        .alu_status(alu_status3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_flags(rsp_flags3), .rsp_err(rsp_err3), .acc(acc3)
    );

    // Behavioural ALU: returns {is_add, overflow, result}
    function automatic logic [9:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] mode);
        logic [7:0] x, y, r;
        logic       ov, is_add;
        x = mode[0] ? ~a : a;
        y = mode[1] ? ~b : b;
        r = 8'h00; ov = 1'b0; is_add = 1'b0;
        case (mode[7:3])
            5'd1: begin
                r = x + y + {7'd0, mode[2]};
                is_add = 1'b1;
                ov = (x[7] == y[7]) && (r[7] != x[7]);
            end
            5'd2: r = x & y;
            5'd3: r = x | y;
            5'd4: r = x ^ y;
            5'd5: r = x;
            5'd6: r = y;
            default: r = 8'h00;
        endcase
        return {is_add, ov, r};
    endfunction

    logic [9:0] ev1, ev3;
    logic       sticky1, sticky3;
    logic [7:0] res1_pipe [0:L1-1];
    logic [7:0] st1_pipe  [0:L1-1];
    logic [7:0] res3_pipe [0:L3-1];
    logic [7:0] st3_pipe  [0:L3-1];

    assign ev1 = alu_eval(alu_a, alu_b, alu_mode);
    assign ev3 = alu_eval(alu_a3, alu_b3, alu_mode3);
    assign alu_out     = res1_pipe[L1-1];
    assign alu_status  = st1_pipe[L1-1];
    assign alu_out3    = res3_pipe[L3-1];
    assign alu_status3 = st3_pipe[L3-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky1 <= 1'b0;
            for (int i = 0; i < L1; i++) begin res1_pipe[i] <= 8'h00; st1_pipe[i] <= 8'h00; end
        end else begin
            sticky1      <= ev1[9] ? ev1[8] : sticky1;
            res1_pipe[0] <= ev1[7:0];
            st1_pipe[0]  <= {4'b0, ~^ev1[7:0], ev1[7], (ev1[9] ? ev1[8] : sticky1), (ev1[7:0] == 8'h00)};
            for (int i = 1; i < L1; i++) begin res1_pipe[i] <= res1_pipe[i-1]; st1_pipe[i] <= st1_pipe[i-1]; end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky3 <= 1'b0;
            for (int i = 0; i < L3; i++) begin res3_pipe[i] <= 8'h00; st3_pipe[i] <= 8'h00; end
        end else begin
            sticky3      <= ev3[9] ? ev3[8] : sticky3;
            res3_pipe[0] <= ev3[7:0];
            st3_pipe[0]  <= {4'b0, ~^ev3[7:0], ev3[7], (ev3[9] ? ev3[8] : sticky3), (ev3[7:0] == 8'h00)};
            for (int i = 1; i < L3; i++) begin res3_pipe[i] <= res3_pipe[i-1]; st3_pipe[i] <= st3_pipe[i-1]; end
        end
    end

    // Drives one command on dut1, waits (bounded) for the response
    task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic use_acc, output int lat);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic send_cmd3(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic use_acc, output int lat);
        cmd_op3 = op; cmd_a3 = a; cmd_b3 = b; cmd_use_acc3 = use_acc; cmd_valid3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        lat = 0;
        while (!rsp_valid3 && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (alu_mode !== 8'h00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin n_err++; $display("[TB] FAIL rst_alu_regs: got %h/%h/%h expected 00/00/00", alu_a, alu_b, alu_mode); end
        n_cmp++; if (rsp_result !== 8'h00 || rsp_flags !== 4'h0 || rsp_err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_payload: got %h/%h/%b expected 00/0/0", rsp_result, rsp_flags, rsp_err); end
        n_cmp++; if (acc !== 8'h00) begin n_err++; $display("[TB] FAIL rst_acc: got %h expected 00", acc); end
        n_cmp++; if (acc3 !== 8'h5A) begin n_err++; $display("[TB] FAIL rst_acc3: got %h expected 5a", acc3); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_add();
        int lat;
        send_cmd(4'd0, 8'h05, 8'h03, 1'b0, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL add_latency: got %0d expected 2", lat); end
        n_cmp++; if (alu_mode !== 8'h08) begin n_err++; $display("[TB] FAIL add_mode: got %h expected 08", alu_mode); end
        n_cmp++; if (rsp_result !== 8'h08) begin n_err++; $display("[TB] FAIL add_result: got %h expected 08", rsp_result); end
        n_cmp++; if (rsp_flags !== 4'b0000) begin n_err++; $display("[TB] FAIL add_flags: got %b expected 0000", rsp_flags); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL add_busy_ready: got %b expected 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_sub_use_acc();
        int lat;
        send_cmd(4'd1, 8'h10, 8'h10, 1'b0, lat);
        n_cmp++; if (alu_mode !== 8'h0E) begin n_err++; $display("[TB] FAIL sub_mode: got %h expected 0e", alu_mode); end
        n_cmp++; if (rsp_result !== 8'h00 || rsp_flags !== 4'b1001) begin n_err++; $display("[TB] FAIL sub_rsp: got %h/%b expected 00/1001", rsp_result, rsp_flags); end
        n_cmp++; if (acc !== 8'h00) begin n_err++; $display("[TB] FAIL sub_acc: got %h expected 00", acc); end
        @(negedge clk);
        send_cmd(4'd7, 8'hEE, 8'h77, 1'b1, lat);
        n_cmp++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_mode !== 8'h0C) begin n_err++; $display("[TB] FAIL inc_issue: got %h/%h/%h expected 00/00/0c", alu_a, alu_b, alu_mode); end
        n_cmp++; if (rsp_result !== 8'h01 || rsp_flags !== 4'b0000) begin n_err++; $display("[TB] FAIL inc_rsp: got %h/%b expected 01/0000", rsp_result, rsp_flags); end
        n_cmp++; if (acc !== 8'h01) begin n_err++; $display("[TB] FAIL inc_acc: got %h expected 01", acc); end
        @(negedge clk);
        send_cmd(4'd8, 8'h01, 8'h55, 1'b1, lat);
        n_cmp++; if (alu_b !== 8'h00 || alu_mode !== 8'h0A || rsp_result !== 8'h00) begin n_err++; $display("[TB] FAIL dec_rsp: got %h/%h/%h expected 00/0a/00", alu_b, alu_mode, rsp_result); end
        @(negedge clk);
    endtask

    task automatic test_overflow_mask();
        int lat;
        send_cmd(4'd0, 8'h7F, 8'h01, 1'b0, lat);
        n_cmp++; if (rsp_result !== 8'h80 || rsp_flags !== 4'b0110) begin n_err++; $display("[TB] FAIL ovf_add: got %h/%b expected 80/0110", rsp_result, rsp_flags); end
        @(negedge clk);
        send_cmd(4'd2, 8'hFF, 8'h0F, 1'b0, lat);
        n_cmp++; if (alu_mode !== 8'h10) begin n_err++; $display("[TB] FAIL and_mode: got %h expected 10", alu_mode); end
        n_cmp++; if (rsp_result !== 8'h0F || rsp_flags !== 4'b1000) begin n_err++; $display("[TB] FAIL ovf_mask: got %h/%b expected 0f/1000", rsp_result, rsp_flags); end
        @(negedge clk);
        send_cmd(4'd5, 8'h0F, 8'h00, 1'b0, lat);
        n_cmp++; if (alu_mode !== 8'h29 || rsp_result !== 8'hF0 || rsp_flags !== 4'b1100) begin n_err++; $display("[TB] FAIL nota_rsp: got %h/%h/%b expected 29/f0/1100", alu_mode, rsp_result, rsp_flags); end
        @(negedge clk);
        send_cmd(4'd6, 8'h00, 8'h0F, 1'b0, lat);
        n_cmp++; if (alu_mode !== 8'h30 || rsp_result !== 8'h0F || acc !== 8'h0F) begin n_err++; $display("[TB] FAIL passb_rsp: got %h/%h/%h expected 30/0f/0f", alu_mode, rsp_result, acc); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int lat;
        send_cmd(4'hC, 8'h33, 8'h44, 1'b0, lat);
        n_cmp++; if (lat !== 0) begin n_err++; $display("[TB] FAIL ill_latency: got %0d expected 0", lat); end
        n_cmp++; if (rsp_err !== 1'b1 || rsp_result !== 8'h00 || rsp_flags !== 4'h0) begin n_err++; $display("[TB] FAIL ill_rsp: got %b/%h/%b expected 1/00/0000", rsp_err, rsp_result, rsp_flags); end
        n_cmp++; if (alu_mode !== 8'h30 || acc !== 8'h0F) begin n_err++; $display("[TB] FAIL ill_side_effect: got %h/%h expected 30/0f", alu_mode, acc); end
        @(negedge clk);
        n_cmp++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL ill_clear: got %b/%b expected 0/0", rsp_err, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        rsp_ready = 1'b0;
        cmd_op = 4'd4; cmd_a = 8'hAA; cmd_b = 8'hFF; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = 4'd3; cmd_a = 8'h01; cmd_b = 8'h02;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL bp_latency: got %0d expected 2", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_result !== 8'h55 || rsp_flags !== 4'b1000 || cmd_ready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%b r=%h f=%b rdy=%b expected 1/55/1000/0", i, rsp_valid, rsp_result, rsp_flags, cmd_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 8'hAA) begin n_err++; $display("[TB] FAIL bp_handshake: got v=%b rdy=%b a=%h expected 0/1/aa", rsp_valid, cmd_ready, alu_a); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++; if (alu_a !== 8'h01 || alu_mode !== 8'h18) begin n_err++; $display("[TB] FAIL b2b_accept: got %h/%h expected 01/18", alu_a, alu_mode); end
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        n_cmp++; if (rsp_result !== 8'h03 || rsp_flags !== 4'b1000) begin n_err++; $display("[TB] FAIL b2b_rsp: got %h/%b expected 03/1000", rsp_result, rsp_flags); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        cmd_op = 4'd0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (alu_a !== 8'h00 || alu_mode !== 8'h00 || acc !== 8'h00 || cmd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rstw_values: got a=%h m=%h acc=%h rdy=%b expected 00/00/00/0", alu_a, alu_mode, acc, cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstw_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
        end
    endtask

    task automatic test_latency3();
        int lat;
        send_cmd3(4'd0, 8'h00, 8'h01, 1'b1, lat);
        n_cmp++; if (lat !== 4) begin n_err++; $display("[TB] FAIL l3_latency: got %0d expected 4", lat); end
        n_cmp++; if (alu_a3 !== 8'h5A || rsp_result3 !== 8'h5B || rsp_flags3 !== 4'b0000 || acc3 !== 8'h5B) begin n_err++; $display("[TB] FAIL l3_rsp: got a=%h r=%h f=%b acc=%h expected 5a/5b/0000/5b", alu_a3, rsp_result3, rsp_flags3, acc3); end
        @(negedge clk);
        cmd_op3 = 4'd3; cmd_a3 = 8'hF0; cmd_b3 = 8'h0F; cmd_use_acc3 = 1'b0; cmd_valid3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (acc3 !== 8'h5A || alu_mode3 !== 8'h00 || rsp_valid3 !== 1'b0) begin n_err++; $display("[TB] FAIL l3_rstw: got acc=%h m=%h v=%b expected 5a/00/0", acc3, alu_mode3, rsp_valid3); end
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid3) lat++; end
        n_cmp++; if (lat !== 0) begin n_err++; $display("[TB] FAIL l3_no_rsp: got %0d valid cycles expected 0", lat); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_use_acc = 1'b0; rsp_ready = 1'b1;
        cmd_valid3 = 1'b0; cmd_op3 = 4'd0; cmd_a3 = 8'h00; cmd_b3 = 8'h00; cmd_use_acc3 = 1'b0; rsp_ready3 = 1'b1;
        test_reset();
        test_add();
        test_sub_use_acc();
        test_overflow_mask();
        test_illegal();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
